shared_reg_arbiter: RTL
=======================

Name: shared_reg_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one WIDTH-bit register bank among N_REQ requesters.
- The register bank is a row of single-bit D flip-flops with synchronous reset.
- Grants one requester at a time, captures its write word and issues a single-cycle load strobe plus data to the bank.
- Sits between the requester blocks and the register bank; it is the only writer of that bank.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 16, register bank width in bits.
- MAX_HOLD, 8, maximum cycles a grant is held waiting for wvalid (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  N_REQ  per-requester access request, level, held until ack or abort.
- wvalid  input  N_REQ  per-requester write-data-valid, honoured only for the granted index.
- wdata  input  N_REQ*WIDTH  flattened write words; requester i occupies bits [i*WIDTH +: WIDTH].
- gnt  output  N_REQ  one-hot grant, registered.
- ack  output  N_REQ  one-cycle pulse to requester i when its word has been loaded.
- reg_ld  output  1  one-cycle load strobe to the register bank.
- reg_d  output  WIDTH  data to the register bank, valid while reg_ld=1, held otherwise.
- busy  output  1  high while the FSM is in GRANT.
- tmo  output  1  one-cycle timeout pulse (tied 0 when the optional feature is compiled out).

Behaviour:
- Reset is synchronous to clk, active-high. Values while rst=1:
  - gnt=0, ack=0, reg_ld=0, reg_d=0, busy=0, tmo=0.
  - state=IDLE, rr pointer=N_REQ-1, so requester 0 has highest priority first.
- Reset mid-grant: the grant drops on the next edge and no load is issued.
- FSM states are IDLE and GRANT.
- IDLE:
  - If req!=0, select winner w as the first set bit searching ptr+1, ptr+2, ... modulo N_REQ.
  - At the edge: gnt<=onehot(w), state<=GRANT.
  - Otherwise stay in IDLE with gnt=0.
- GRANT, index g:
  - If wvalid[g]=1 at the edge:
    - reg_d<=wdata slice g, reg_ld<=1, ack[g]<=1, gnt<=0.
    - ptr<=g, state<=IDLE.
  - Else if req[g]=0 (abort):
    - gnt<=0, ptr<=g, state<=IDLE.
    - No reg_ld, no ack.
  - Else hold gnt.
  - wvalid/wdata of non-granted requesters are ignored.
  - Changes to req of other requesters do not pre-empt the grant.
- Timing and latency:
  - req sampled high at edge t gives gnt high from t+1.
  - wvalid sampled at edge t+1 gives reg_ld and ack high in cycle t+2.
  - In that same cycle the FSM is back in IDLE and re-arbitrates, so the next gnt appears in cycle t+3.
  - Peak throughput is one load per 2 cycles.
- reg_ld and ack are exactly one cycle wide and never assert together with any gnt bit in the same cycle.
- Fairness:
  - A requester that has just been served or aborted gets lowest priority next round.
  - With all N_REQ requesting continuously, grants rotate 0,1,2,...,N_REQ-1,0.
- Wrap-around: the search from ptr+1 wraps from N_REQ-1 to 0. A sole requester equal to ptr is still granted.
- busy = (state==GRANT), decoded from registered state.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- When defined:
  - A hold counter clears on entry to GRANT and increments each cycle in GRANT without wvalid[g].
  - If the counter reaches MAX_HOLD-1 with wvalid[g]=0 and req[g]=1:
    - gnt<=0, ptr<=g, state<=IDLE, tmo<=1 for one cycle.
    - No load and no ack.
  - wvalid[g]=1 on that same edge takes precedence: a normal load, no tmo.
- When undefined:
  - There is no counter; the grant is held indefinitely until wvalid or abort.
  - tmo is constant 0.

Test Plan:
- Single write: req[2]=1 at cycle 0, wvalid[2]=1 with wdata slice 2=16'hA5C3 at cycle 1 → gnt=4'b0100 in cycle 1; reg_ld=1, reg_d=16'hA5C3, ack[2]=1 in cycle 2; gnt=0 in cycle 2.
- Round-robin: req=4'b1111 held and wvalid always 1 → grant order 0,1,2,3,0; reg_ld every 2nd cycle; reg_d follows the per-requester patterns 16'h0001/0002/0004/0008.
- Abort: req[1] granted, then req[1] drops before wvalid → gnt returns to 0 with no reg_ld or ack. A pending req[3] is granted next, and with req[1] reasserted its priority is below req[3].
- Reset mid-grant: rst=1 for one cycle while gnt=4'b0010 → all outputs 0 next cycle; after release, req=4'b1010 grants requester 1 first (ptr=3).
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=8): req[0]=1, wvalid=0 → gnt held 8 cycles, then tmo=1 for one cycle, gnt=0, no reg_ld. In a variant with wvalid on the 8th cycle, a load occurs and tmo=0.
- Non-granted wvalid: gnt=4'b0001, wvalid[3]=1 with data 16'hFFFF → no reg_ld until wvalid[0]; reg_d equals requester 0's word.

Source files
------------

// File: rtl/shared_reg_arbiter_if.sv
// Bus between the requester blocks, the shared register bank and the
// round-robin arbiter that is the bank's only writer.
//   master : requester side (drives req/wvalid/wdata, observes grant/ack/load)
//   slave  : arbiter side
interface shared_reg_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       wvalid;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       ack;
  logic                   reg_ld;
  logic [WIDTH-1:0]       reg_d;
  logic                   busy;
  logic                   tmo;

  modport master (
    output req, wvalid, wdata,
    input  gnt, ack, reg_ld, reg_d, busy, tmo
  );

  modport slave (
    input  req, wvalid, wdata,
    output gnt, ack, reg_ld, reg_d, busy, tmo
  );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter/sequencer sharing one WIDTH-bit register bank among
// N_REQ requesters. One requester is granted at a time; its word is passed
// to the bank with a single-cycle load strobe and the requester is acked.
// Optional feature: define ARB_TIMEOUT_EN to drop a grant that waits
// MAX_HOLD cycles without wvalid (tmo pulses). Without it tmo is tied 0.
module shared_reg_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  shared_reg_arbiter_if.slave  bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  // Reject parameter sets outside the supported range at elaboration.
  if (N_REQ < 2 || N_REQ > 8 || WIDTH < 1 || MAX_HOLD < 1) begin : g_param_check
    $error("shared_reg_arbiter: unsupported parameter set");
  end

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               reg_ld_q, reg_ld_d;
  logic [WIDTH-1:0]   reg_d_q, reg_d_d;
  logic [IDX_W:0]     win_s;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               tmo_q, tmo_d;
`endif

  // First set request bit searching p+1, p+2, ... modulo N_REQ; p itself is
  // visited last so a sole requester equal to the pointer still wins.
  // Returns {found, index}.
  function automatic logic [IDX_W:0] pick_winner(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] p);
    logic             found;
    logic [IDX_W-1:0] w;
    int               idx;
    found = 1'b0;
    w     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(p) + k) % N_REQ;
      if (!found && r[IDX_W'(idx)]) begin
        found = 1'b1;
        w     = IDX_W'(idx);
      end else begin
        found = found;
      end
    end
    return {found, w};
  endfunction

  assign win_s = pick_winner(bus.req, ptr_q);

  // Next-state and registered-output decode for the IDLE/GRANT sequencer.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    gnt_d    = gnt_q;
    ack_d    = '0;
    reg_ld_d = 1'b0;
    reg_d_d  = reg_d_q;
`ifdef ARB_TIMEOUT_EN
    hold_d   = hold_q;
    tmo_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (win_s[IDX_W]) begin
          gidx_d  = win_s[IDX_W-1:0];
          gnt_d   = ONE_HOT0 << win_s[IDX_W-1:0];
          state_d = ST_GRANT;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (bus.wvalid[gidx_q]) begin
          // Load wins over abort and timeout on the same edge.
          reg_d_d  = bus.wdata[gidx_q*WIDTH +: WIDTH];
          reg_ld_d = 1'b1;
          ack_d    = ONE_HOT0 << gidx_q;
          gnt_d    = '0;
          ptr_d    = gidx_q;
          state_d  = ST_IDLE;
        end else if (!bus.req[gidx_q]) begin
          // Requester gave up: release without touching the bank.
          gnt_d   = '0;
          ptr_d   = gidx_q;
          state_d = ST_IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == HOLD_LAST) begin
          gnt_d   = '0;
          ptr_d   = gidx_q;
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
`else
        else begin
          state_d = ST_GRANT;
        end
`endif
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= PTR_RST;
      gidx_q   <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      reg_ld_q <= 1'b0;
      reg_d_q  <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_q   <= '0;
      tmo_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      reg_ld_q <= reg_ld_d;
      reg_d_q  <= reg_d_d;
`ifdef ARB_TIMEOUT_EN
      hold_q   <= hold_d;
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.ack    = ack_q;
  assign bus.reg_ld = reg_ld_q;
  assign bus.reg_d  = reg_d_q;
  assign bus.busy   = (state_q == ST_GRANT);
`ifdef ARB_TIMEOUT_EN
  assign bus.tmo    = tmo_q;
`else
  assign bus.tmo    = 1'b0;
`endif

endmodule
